// File: rtl/tx_ring_writer.sv
// tx_ring_writer: writes a valid/ready byte stream into the FT600 bridge TX ring with
// full-based back-pressure, occupancy reporting and byte/packet/stall statistics.
module tx_ring_writer #(
   parameter int TX_BUFFER       = 16,
   parameter int TX_BUFFER_WIDTH = $clog2(TX_BUFFER)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       s_valid_i,
   input  logic [7:0]                 s_data_i,
   input  logic                       s_last_i,
   output logic                       s_ready_o,
   output logic [8*TX_BUFFER-1:0]     tx_buf_o,
   output logic [TX_BUFFER_WIDTH-1:0] tx_buf_send_o,
   input  logic [TX_BUFFER_WIDTH-1:0] tx_buf_sent_i,
   output logic [TX_BUFFER_WIDTH-1:0] level_o,
   output logic                       stalled_o,
   input  logic                       stat_clear_i,
   output logic [31:0]                byte_count_o,
   output logic [15:0]                pkt_count_o,
   output logic [15:0]                stall_count_o
);
   localparam logic [TX_BUFFER_WIDTH-1:0] PTR_ONE = {{(TX_BUFFER_WIDTH-1){1'b0}}, 1'b1};
   logic [TX_BUFFER-1:0][7:0] buf_q, buf_d;
   logic [TX_BUFFER_WIDTH-1:0] send_q, send_d, sent_q;
   logic [31:0] byte_q, byte_d;
   logic [15:0] pkt_q, pkt_d, stall_q, stall_d;
   logic stalled_q, full, acc, stall;
   // One slot is always left empty so full and empty stay distinguishable
   assign full          = (send_q + PTR_ONE) == sent_q;
   assign s_ready_o     = !full;
   assign acc           = s_valid_i && !full;
   assign stall         = s_valid_i && full;
   assign tx_buf_o      = buf_q;
   assign tx_buf_send_o = send_q;
   assign level_o       = send_q - sent_q;
   assign stalled_o     = stalled_q;
   assign byte_count_o  = byte_q;
   assign pkt_count_o   = pkt_q;
   assign stall_count_o = stall_q;
   always_comb begin
      buf_d = buf_q;
      if (acc) buf_d[send_q] = s_data_i;
      send_d  = acc ? send_q + PTR_ONE : send_q;
      byte_d  = stat_clear_i ? '0 : byte_q + {31'b0, acc};
      pkt_d   = stat_clear_i ? '0 : pkt_q + {15'b0, acc && s_last_i};
      stall_d = stat_clear_i ? '0 : (stall && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q     <= '0;
         send_q    <= '0;
         sent_q    <= '0;
         byte_q    <= '0;
         pkt_q     <= '0;
         stall_q   <= '0;
         stalled_q <= 1'b0;
      end else begin
         buf_q     <= buf_d;
         send_q    <= send_d;
         sent_q    <= tx_buf_sent_i;
         byte_q    <= byte_d;
         pkt_q     <= pkt_d;
         stall_q   <= stall_d;
         stalled_q <= stall;
      end
   end
endmodule

// File: tb/tb_tx_ring_writer.sv
// tb_tx_ring_writer: randomized and directed stimulus for tx_ring_writer, checked every
// cycle against a queue-free ring model plus literal expectations for the key scenarios.
module tb_tx_ring_writer;
   localparam int N = 16;
   logic clk = 1'b0, rst_n = 1'b0;
   logic s_valid = 1'b0, s_last = 1'b0, stat_clear = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic [3:0] tx_buf_sent = 4'd0;
   logic s_ready, stalled;
   logic [8*N-1:0] tx_buf;
   logic [3:0] tx_buf_send, level;
   logic [31:0] byte_count;
   logic [15:0] pkt_count, stall_count;
   int checks = 0, errors = 0;
   tx_ring_writer #(.TX_BUFFER(N)) dut (
      .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
      .s_ready_o(s_ready), .tx_buf_o(tx_buf), .tx_buf_send_o(tx_buf_send),
      .tx_buf_sent_i(tx_buf_sent), .level_o(level), .stalled_o(stalled),
      .stat_clear_i(stat_clear), .byte_count_o(byte_count), .pkt_count_o(pkt_count),
      .stall_count_o(stall_count)
   );
   always #5 clk = ~clk;
   // Reference: ring as a byte array, write index and the one-cycle-old consumer index
   logic [N-1:0][7:0] m_buf = '0;
   int m_wp = 0, m_sent = 0;
   int unsigned m_bytes = 0, m_pkts = 0, m_stalls = 0;
   logic m_stalled = 1'b0;
   logic m_full;
   int m_level;
   assign m_full  = ((m_wp + 1) % N) == m_sent;
   assign m_level = (m_wp - m_sent + N) % N;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_buf <= '0; m_wp <= 0; m_sent <= 0; m_stalled <= 1'b0;
         m_bytes <= 0; m_pkts <= 0; m_stalls <= 0;
      end else begin
         if (s_valid && !m_full) begin
            m_buf[m_wp] <= s_data;
            m_wp <= (m_wp + 1) % N;
         end
         m_sent    <= int'(tx_buf_sent);
         m_stalled <= s_valid && m_full;
         m_bytes   <= stat_clear ? 0 : (m_bytes + ((s_valid && !m_full) ? 1 : 0)) % 33'h1_0000_0000;
         m_pkts    <= stat_clear ? 0 : (m_pkts + ((s_valid && !m_full && s_last) ? 1 : 0)) % 65536;
         m_stalls  <= stat_clear ? 0 : (s_valid && m_full && m_stalls < 65535) ? m_stalls + 1 : m_stalls;
      end
   end
   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
      end
   endtask
   always @(negedge clk) begin
      chk("s_ready", 128'(s_ready), 128'(!m_full));
      chk("tx_buf_send", 128'(tx_buf_send), 128'(m_wp));
      chk("level", 128'(level), 128'(m_level));
      chk("stalled", 128'(stalled), 128'(m_stalled));
      chk("byte_count", 128'(byte_count), 128'(m_bytes));
      chk("pkt_count", 128'(pkt_count), 128'(m_pkts));
      chk("stall_count", 128'(stall_count), 128'(m_stalls));
      chk("tx_buf", tx_buf, m_buf);
   end
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic track();
      tx_buf_sent = 4'((m_wp + N - 1) % N);
   endtask
   initial begin
      repeat (2) step();
      chk("reset ready", 128'(s_ready), 128'd1);
      chk("reset level", 128'(level), 128'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         s_valid = 1'b1; s_data = 8'(i);
         step();
      end
      s_data = 8'h0F;
      chk("t1 send", 128'(tx_buf_send), 128'd15);
      chk("t1 level", 128'(level), 128'd15);
      chk("t1 ready", 128'(s_ready), 128'd0);
      chk("t1 slot3", 128'(tx_buf[8*3+:8]), 128'h03);
      chk("t1 slot14", 128'(tx_buf[8*14+:8]), 128'h0E);
      step();
      chk("t1 stall_count", 128'(stall_count), 128'd1);
      chk("t1 stalled", 128'(stalled), 128'd1);
      tx_buf_sent = 4'd1;
      step();
      chk("t2 ready", 128'(s_ready), 128'd1);
      step();
      chk("t2 wrap send", 128'(tx_buf_send), 128'd0);
      chk("t2 level", 128'(level), 128'd15);
      chk("t2 slot15", 128'(tx_buf[8*15+:8]), 128'h0F);
      s_valid = 1'b0; stat_clear = 1'b1; track();
      step();
      stat_clear = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         s_valid = 1'b1; s_data = 8'($urandom); track();
         step();
      end
      s_valid = 1'b0;
      chk("t3 byte_count", 128'(byte_count), 128'd1000);
      chk("t3 stall_count", 128'(stall_count), 128'd0);
      stat_clear = 1'b1; track();
      step();
      stat_clear = 1'b0;
      for (int i = 0; i < 15; i++) begin
         s_valid = 1'b1; s_data = 8'($urandom); s_last = (i % 3) == 2; track();
         step();
      end
      chk("t4 pkt_count", 128'(pkt_count), 128'd5);
      chk("t4 byte_count", 128'(byte_count), 128'd15);
      for (int i = 0; i < 3; i++) begin
         s_data = 8'($urandom); s_last = i == 2; stat_clear = i == 2; track();
         step();
      end
      chk("t4 clr byte", 128'(byte_count), 128'd0);
      chk("t4 clr pkt", 128'(pkt_count), 128'd0);
      chk("t4 clr stall", 128'(stall_count), 128'd0);
      s_last = 1'b0; stat_clear = 1'b0;
      tx_buf_sent = 4'(m_wp);
      repeat (70000) step();
      chk("t5 stall sat", 128'(stall_count), 128'hFFFF);
      chk("t5 stalled", 128'(stalled), 128'd1);
      s_valid = 1'b0; tx_buf_sent = 4'(m_wp);
      repeat (2) step();
      chk("t6 drained", 128'(level), 128'd0);
      s_valid = 1'b1;
      repeat (7) step();
      chk("t6 level7", 128'(level), 128'd7);
      #1 rst_n = 1'b0;
      #1;
      chk("t6 async send", 128'(tx_buf_send), 128'd0);
      chk("t6 async level", 128'(level), 128'd0);
      chk("t6 async ready", 128'(s_ready), 128'd1);
      chk("t6 async bytes", 128'(byte_count), 128'd0);
      s_valid = 1'b0; tx_buf_sent = 4'd0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         int lvl;
         lvl = (m_wp - int'(tx_buf_sent) + N) % N;
         s_valid     = $urandom_range(0, 3) != 0;
         s_data      = 8'($urandom);
         s_last      = $urandom_range(0, 3) == 0;
         stat_clear  = $urandom_range(0, 63) == 0;
         tx_buf_sent = 4'((int'(tx_buf_sent) + $urandom_range(0, lvl)) % N);
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
